// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and default tap masks for the lfsr block.
// Tap masks are returned at full MAX_WIDTH and truncated by the caller.
package lfsr_pkg;

  localparam int MAX_WIDTH          = 4096;
  localparam int MIN_WIDTH          = 3;
  localparam int DEFAULT_WORD_WIDTH = 512;
  localparam int DEFAULT_SEED       = 1;
  localparam int DEFAULT_STEPS      = 1;

  // Known maximal-length masks; unknown widths yield zero so the
  // top-bit tap check in lfsr rejects them unless TAPS is overridden.
  function automatic logic [MAX_WIDTH-1:0] default_taps(
    input int width
  );
    logic [MAX_WIDTH-1:0] t;
    t = '0;
    case (width)
      8: begin
        t[7:0] = 8'hB8;
      end
      16: begin
        t[15:0] = 16'hB400;
      end
      32: begin
        t[31] = 1'b1;
        t[21] = 1'b1;
        t[1]  = 1'b1;
        t[0]  = 1'b1;
      end
      512: begin
        t[511] = 1'b1;
        t[509] = 1'b1;
        t[506] = 1'b1;
        t[503] = 1'b1;
      end
      default: begin
        t = '0;
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Fibonacci shift.
// Feedback is the XOR of tapped bits, entering at bit 0.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int                    WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] TAPS       =
    WORD_WIDTH'(default_taps(WORD_WIDTH))
) (
  input  logic [WORD_WIDTH-1:0] s_i,
  output logic [WORD_WIDTH-1:0] f_o
);

  logic fb;

  // Parity of the tapped bits, then left shift with fb at the bottom.
  always_comb begin
    fb  = ^(s_i & TAPS);
    f_o = {s_i[WORD_WIDTH-2:0], fb};
  end

endmodule

// File: rtl/lfsr.sv
// lfsr: free-running Fibonacci LFSR, STEPS shifts per clock, one register.
// Optional LFSR_LOCKUP_GUARD_EN reloads SEED from an all-zero state.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int                    WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] TAPS       =
    WORD_WIDTH'(default_taps(WORD_WIDTH)),
  parameter logic [WORD_WIDTH-1:0] SEED       =
    WORD_WIDTH'(DEFAULT_SEED),
  parameter int                    STEPS      = DEFAULT_STEPS
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WORD_WIDTH-1:0] rand_out
);

  if (WORD_WIDTH < MIN_WIDTH || WORD_WIDTH > MAX_WIDTH) begin : g_bad_w
    $error("lfsr: WORD_WIDTH out of range 3..4096");
  end

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: SEED must be non-zero");
  end

  if (TAPS[WORD_WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr: TAPS top bit must be set");
  end

  if (STEPS < 1 || STEPS > WORD_WIDTH) begin : g_bad_steps
    $error("lfsr: STEPS out of range 1..WORD_WIDTH");
  end

  logic [WORD_WIDTH-1:0] state_q;
  logic [WORD_WIDTH-1:0] state_d;
  logic [WORD_WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step #(
      .WORD_WIDTH (WORD_WIDTH),
      .TAPS       (TAPS)
    ) u_step (
      .s_i (chain[g]),
      .f_o (chain[g+1])
    );
  end

`ifdef LFSR_LOCKUP_GUARD_EN
  logic zero_st;

  // Recover from a corrupted all-zero state by reseeding.
  always_comb begin
    zero_st = ~|state_q;
    state_d = chain[STEPS];
    if (zero_st) begin
      state_d = SEED;
    end
  end
`else
  // Next state is the end of the unrolled shift chain.
  always_comb begin
    state_d = chain[STEPS];
  end
`endif

  // State register; reset has priority and reloads SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign rand_out = state_q;

endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: directed checks of the lfsr block at 8 and 512 bits.
// Lockup expectations follow LFSR_LOCKUP_GUARD_EN.
module tb_lfsr;

  logic         clk;
  logic         rst;
  logic [7:0]   r8;
  logic [7:0]   r8s2;
  logic [511:0] r512;

  int total;
  int bad;

  lfsr #(
    .WORD_WIDTH (8),
    .TAPS       (8'hB8),
    .SEED       (8'h01),
    .STEPS      (1)
  ) u8 (
    .clk      (clk),
    .rst      (rst),
    .rand_out (r8)
  );

  lfsr #(
    .WORD_WIDTH (8),
    .TAPS       (8'hB8),
    .SEED       (8'h01),
    .STEPS      (2)
  ) u8s2 (
    .clk      (clk),
    .rst      (rst),
    .rand_out (r8s2)
  );

  lfsr u512 (
    .clk      (clk),
    .rst      (rst),
    .rand_out (r512)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (r8 !== 8'h01) begin
      $display("FAIL reset8 got=%h want=01", r8);
      bad++;
    end
    total++;
    if (r8s2 !== 8'h01) begin
      $display("FAIL reset8s2 got=%h want=01", r8s2);
      bad++;
    end
    total++;
    if (r512 !== 512'd1) begin
      $display("FAIL reset512 got_lo=%h want=1", r512[31:0]);
      bad++;
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp [7];
    exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (r8 !== exp[i]) begin
        $display("FAIL seq[%0d] got=%h want=%h", i, r8, exp[i]);
        bad++;
      end
    end
  endtask

  task automatic test_period();
    bit seen [256];
    int distinct;
    int zero_hits;
    int early;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct  = 0;
    zero_hits = 0;
    early     = 0;
    do_reset();
    seen[r8] = 1'b1;
    distinct = 1;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk);
      #1;
      if (r8 === 8'h00) zero_hits++;
      if (k < 255 && r8 === 8'h01) early++;
      if (k < 255 && !seen[r8]) begin
        seen[r8] = 1'b1;
        distinct++;
      end
    end
    total++;
    if (r8 !== 8'h01) begin
      $display("FAIL period_wrap got=%h want=01", r8);
      bad++;
    end
    total++;
    if (zero_hits != 0) begin
      $display("FAIL period_zero got=%0d want=0", zero_hits);
      bad++;
    end
    total++;
    if (early != 0) begin
      $display("FAIL period_early got=%0d want=0", early);
      bad++;
    end
    total++;
    if (distinct != 255) begin
      $display("FAIL period_distinct got=%0d want=255", distinct);
      bad++;
    end
  endtask

  task automatic test_steps2();
    logic [7:0] exp [4];
    exp = '{8'h01, 8'h04, 8'h11, 8'h47};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (r8s2 !== exp[i]) begin
        $display("FAIL steps2[%0d] got=%h want=%h", i, r8s2, exp[i]);
        bad++;
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (r8 !== 8'h23) begin
      $display("FAIL mid_pre got=%h want=23", r8);
      bad++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (r8 !== 8'h01) begin
      $display("FAIL mid_reload got=%h want=01", r8);
      bad++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (r8 !== 8'h02) begin
      $display("FAIL mid_restart got=%h want=02", r8);
      bad++;
    end
  endtask

  task automatic test_default_width();
    logic [511:0] exp;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      exp = 512'd1 << k;
      total++;
      if (r512 !== exp) begin
        $display("FAIL w512[%0d] got_lo=%h want_lo=%h",
                 k, r512[31:0], exp[31:0]);
        bad++;
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (r512 === '0 || $isunknown(r512)) begin
      $display("FAIL w512_clk10 got_lo=%h want=nonzero", r512[31:0]);
      bad++;
    end
  endtask

  task automatic test_lockup();
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    force u8.state_q = 8'h00;
    release u8.state_q;
    #1;
    total++;
    if (r8 !== 8'h00) begin
      $display("FAIL lock_deposit got=%h want=00", r8);
      bad++;
    end
    @(posedge clk);
    #1;
`ifdef LFSR_LOCKUP_GUARD_EN
    total++;
    if (r8 !== 8'h01) begin
      $display("FAIL lock_reseed got=%h want=01", r8);
      bad++;
    end
    @(posedge clk);
    #1;
    total++;
    if (r8 !== 8'h02) begin
      $display("FAIL lock_next got=%h want=02", r8);
      bad++;
    end
`else
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (r8 !== 8'h00) begin
        $display("FAIL lock_stuck[%0d] got=%h want=00", i, r8);
        bad++;
      end
    end
`endif
    do_reset();
    total++;
    if (r8 !== 8'h01) begin
      $display("FAIL lock_rst got=%h want=01", r8);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    test_reset();
    test_sequence();
    test_period();
    test_steps2();
    test_mid_reset();
    test_default_width();
    test_lockup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
